// File: rtl/column_frame_sequencer.sv
// Frame-buffer walker feeding the matrix output stage: reads one word per channel
// per byte slot, holds it, and hands it over with a single command pulse per slot.
module column_frame_sequencer #(
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = 8,
  parameter int COLUMNS          = 16,
  parameter int BYTES_PER_COLUMN = 24,
  parameter int ADDR_WIDTH       = $clog2(COLUMNS * BYTES_PER_COLUMN)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               frame_start,
  input  logic                               extra_bit_cfg,
  output logic                               rd_en,
  output logic [ADDR_WIDTH-1:0]              rd_addr,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
  output logic [SPI_SIZE-1:0]                data_out [CHANNEL_NUMBER],
  output logic                               new_image,
  output logic                               new_column,
  output logic                               next_data,
  output logic                               extra_bit,
  input  logic                               tx_finish,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               frame_dropped
);

  localparam int COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int BYTE_W = (BYTES_PER_COLUMN > 1) ? $clog2(BYTES_PER_COLUMN) : 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_LATCH     = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  logic [2:0]        state, state_nxt;
  logic [COL_W-1:0]  col_idx;
  logic [BYTE_W-1:0] byte_idx;
  logic              pending;
  logic              launch;
  logic              last_slot;
  logic              last_byte;
  logic              issue_fire;

  assign launch     = (state == ST_IDLE) && (frame_start || pending);
  assign last_byte  = (byte_idx == BYTE_W'(BYTES_PER_COLUMN - 1));
  assign last_slot  = last_byte && (col_idx == COL_W'(COLUMNS - 1));
  assign issue_fire = (state == ST_ISSUE) && tx_finish;

  assign rd_en         = (state == ST_FETCH);
  assign busy          = (state != ST_IDLE) && (state != ST_DONE);
  assign frame_done    = (state == ST_DONE);
  assign frame_dropped = frame_start && (state != ST_IDLE) && pending;

  // Exactly one command per slot, chosen by where the slot sits in the frame.
  assign new_image  = issue_fire && (byte_idx == '0) && (col_idx == '0);
  assign new_column = issue_fire && (byte_idx == '0) && (col_idx != '0);
  assign next_data  = issue_fire && (byte_idx != '0);

  always_comb begin
    // NOTE: next-state defaults to hold before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE:      if (launch) state_nxt = ST_FETCH;
      ST_FETCH:     state_nxt = ST_LATCH;
      ST_LATCH:     state_nxt = ST_ISSUE;
      ST_ISSUE:     if (tx_finish) state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!tx_finish) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_finish) state_nxt = last_slot ? ST_DONE : ST_FETCH;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      col_idx   <= '0;
      byte_idx  <= '0;
      pending   <= 1'b0;
      rd_addr   <= '0;
      extra_bit <= 1'b0;
      // NOTE: data_out is a small holding register bank, not a RAM, so it is reset to drive zeros.
      for (int k = 0; k < CHANNEL_NUMBER; k++) data_out[k] <= '0;
    end else begin
      state <= state_nxt;

      // Launching consumes the pending request; a request in that same cycle re-arms it.
      if (state == ST_IDLE) pending <= pending & frame_start;
      else if (frame_start) pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (launch) begin
            rd_addr   <= '0;
            extra_bit <= extra_bit_cfg;
          end
        end
        ST_LATCH: begin
          for (int k = 0; k < CHANNEL_NUMBER; k++)
            data_out[k] <= rd_data[k*SPI_SIZE +: SPI_SIZE];
        end
        ST_WAIT_DONE: begin
          // Linear address col*BYTES_PER_COLUMN+byte always steps by one, even across a column wrap.
          if (tx_finish && !last_slot) begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
            if (last_byte) begin
              byte_idx <= '0;
              col_idx  <= col_idx + COL_W'(1);
            end else begin
              byte_idx <= byte_idx + BYTE_W'(1);
            end
          end
        end
        ST_DONE: begin
          col_idx  <= '0;
          byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_column_frame_sequencer.sv
// Scoreboard bench for column_frame_sequencer: a frame-level reference model queues
// the expected reads and commands per accepted request; a monitor checks DUT activity.
module tb_column_frame_sequencer;

  localparam int CH    = 3;
  localparam int SW    = 8;
  localparam int COLS  = 2;
  localparam int BPC   = 3;
  localparam int SLOTS = COLS * BPC;
  localparam int AW    = $clog2(SLOTS);

  typedef enum logic [1:0] {CMD_IMAGE = 2'd1, CMD_COLUMN = 2'd2, CMD_NEXT = 2'd3} cmd_e;
  typedef struct {
    cmd_e             cmd;
    logic [CH*SW-1:0] data;
    logic             xb;
  } slot_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic              extra_bit_cfg;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [CH*SW-1:0]  rd_data;
  logic [SW-1:0]     data_out [CH];
  logic              new_image, new_column, next_data;
  logic              extra_bit;
  logic              tx_finish;
  logic              busy, frame_done, frame_dropped;

  column_frame_sequencer #(
    .CHANNEL_NUMBER(CH), .SPI_SIZE(SW), .COLUMNS(COLS), .BYTES_PER_COLUMN(BPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .extra_bit_cfg(extra_bit_cfg),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out),
    .new_image(new_image), .new_column(new_column), .next_data(next_data),
    .extra_bit(extra_bit), .tx_finish(tx_finish), .busy(busy),
    .frame_done(frame_done), .frame_dropped(frame_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame buffer with one-cycle synchronous read.
  logic [CH*SW-1:0] mem [SLOTS];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Output stage: goes busy for busy_len cycles after each command.
  int   busy_len = 5;
  int   stage_cnt;
  logic hold_low;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_cnt <= 0;
    else if (new_image || new_column || next_data) stage_cnt <= busy_len;
    else if (stage_cnt > 0) stage_cnt <= stage_cnt - 1;
  end
  assign tx_finish = (stage_cnt == 0) && !hold_low;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [AW-1:0] exp_addr [$];
  slot_t         exp_slot [$];
  int            outstanding = 0;
  int            frames_exp  = 0;
  int            drops_exp   = 0;
  int            done_seen   = 0;
  int            drops_seen  = 0;
  int            cmd_seen    = 0;

  function automatic cmd_e exp_cmd(input int s);
    if (s == 0) return CMD_IMAGE;
    if (s % BPC == 0) return CMD_COLUMN;
    return CMD_NEXT;
  endfunction

  // One frame in flight plus one waiting; anything beyond that is dropped.
  task automatic request();
    if (outstanding < 2) begin
      for (int s = 0; s < SLOTS; s++) begin
        exp_addr.push_back(AW'(s));
        exp_slot.push_back('{cmd: exp_cmd(s), data: mem[s], xb: extra_bit_cfg});
      end
      outstanding++;
      frames_exp++;
    end else begin
      drops_exp++;
    end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((outstanding != 0 || stage_cnt != 0) && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_outstanding", outstanding, 0);
  endtask

  task automatic wait_cmds(input int target, input int max_cycles);
    int n = 0;
    while (cmd_seen < target && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_count_reached", cmd_seen, target);
  endtask

  logic [CH*SW-1:0] dout_vec;
  logic [CH*SW-1:0] held_data = '0;
  slot_t            mon_slot;
  cmd_e             act_cmd;
  assign dout_vec = {data_out[2], data_out[1], data_out[0]};

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        check("rd_en_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) check("rd_addr", rd_addr, exp_addr.pop_front());
      end
      if (new_image || new_column || next_data) begin
        check("cmd_onehot", 32'(new_image) + 32'(new_column) + 32'(next_data), 1);
        check("cmd_while_tx_finish", tx_finish, 1);
        check("cmd_expected", exp_slot.size() > 0, 1);
        if (exp_slot.size() > 0) begin
          mon_slot = exp_slot.pop_front();
          act_cmd  = new_image ? CMD_IMAGE : (new_column ? CMD_COLUMN : CMD_NEXT);
          check("cmd_kind", act_cmd, mon_slot.cmd);
          check("cmd_data", dout_vec, mon_slot.data);
          check("extra_bit", extra_bit, mon_slot.xb);
        end
        held_data = dout_vec;
        cmd_seen++;
      end
      if (stage_cnt > 0) check("data_stable", dout_vec, held_data);
      if (frame_dropped) drops_seen++;
      if (frame_done) begin
        done_seen++;
        check("done_busy_low", busy, 0);
        check("done_expected", outstanding > 0, 1);
        if (outstanding > 0) begin
          outstanding--;
          check("done_slots_left", exp_slot.size(), outstanding * SLOTS);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_cmds"}, {new_image, new_column, next_data}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_dropped"}, frame_dropped, 0);
    check({tag, "_extra_bit"}, extra_bit, 0);
    check({tag, "_data_out"}, dout_vec, 0);
  endtask

  initial begin
    int base, d0, p0;
    rst_n = 1'b0; frame_start = 1'b0; extra_bit_cfg = 1'b0; hold_low = 1'b0;
    for (int i = 0; i < SLOTS; i++) mem[i] = CH*SW'($urandom);
    mem[0] = 24'hA53CF0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_rd_en", rd_en, 0);
    end
    check_all_zero("idle");
    @(posedge clk); #1;

    // Directed frame: latency, first word split across channels.
    extra_bit_cfg = 1'b1;
    request();
    @(negedge clk);
    check("fetch_rd_en", rd_en, 1);
    check("busy_after_launch", busy, 1);
    @(negedge clk);
    @(negedge clk);
    check("first_cmd_latency", new_image, 1);
    check("ch2_word", data_out[2], 8'hA5);
    check("ch1_word", data_out[1], 8'h3C);
    check("ch0_word", data_out[0], 8'hF0);
    @(posedge clk); #1;
    wait_idle(500);
    check("frame1_done_count", done_seen, 1);
    check("frame1_busy_low", busy, 0);
    check("data_held_after_frame", dout_vec, mem[SLOTS-1]);

    // tx_finish held low in ISSUE: nothing fires until it rises.
    extra_bit_cfg = 1'b0;
    hold_low = 1'b1;
    request();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_no_cmd", {new_image, new_column, next_data}, 0);
    end
    check("hold_busy", busy, 1);
    @(posedge clk); #1;
    hold_low = 1'b0;
    @(negedge clk);
    check("release_cmd_fires", new_image, 1);
    @(posedge clk); #1;
    wait_idle(500);

    // Three requests in one frame: one pending, one dropped.
    d0 = done_seen; p0 = drops_seen;
    request();
    repeat (4) @(posedge clk); #1;
    request();
    repeat (4) @(posedge clk); #1;
    request();
    wait_idle(1000);
    check("pending_two_done", done_seen - d0, 2);
    check("pending_one_drop", drops_seen - p0, 1);

    // Request landing exactly in the DONE cycle becomes pending.
    d0 = done_seen; p0 = drops_seen;
    base = cmd_seen;
    request();
    wait_cmds(base + SLOTS, 500);
    repeat (6) @(posedge clk); #1;
    check("in_done_cycle", frame_done, 1);
    request();
    wait_idle(1000);
    check("done_cycle_two_done", done_seen - d0, 2);
    check("done_cycle_no_drop", drops_seen - p0, 0);

    // Reset during the third slot aborts the frame; next frame starts over.
    extra_bit_cfg = 1'b1;
    d0 = done_seen;
    base = cmd_seen;
    request();
    wait_cmds(base + 3, 500);
    rst_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_addr.delete();
    exp_slot.delete();
    frames_exp -= outstanding;
    outstanding = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_no_done", done_seen, d0);
    request();
    @(negedge clk);
    check("restart_addr0_en", rd_en, 1);
    check("restart_addr0", rd_addr, 0);
    wait_idle(500);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      busy_len = $urandom_range(1, 6);
      repeat ($urandom_range(0, 15)) @(posedge clk);
      #1;
      if (outstanding == 0 && stage_cnt == 0) begin
        extra_bit_cfg = 1'($urandom);
        for (int i = 0; i < SLOTS; i++) mem[i] = CH*SW'($urandom);
      end
      request();
    end
    wait_idle(5000);

    check("total_done", done_seen, frames_exp);
    check("total_dropped", drops_seen, drops_exp);
    check("queues_empty", exp_addr.size() + exp_slot.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
